// File: rtl/crtc_mode_pkg.sv
// Shared types and the CRTC mode timing ROM used by the mode loader.
// Each table row holds the R0..R11 values for one display mode.
package crtc_mode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VB,
        ST_ADDR,
        ST_DATA,
        ST_RESTORE,
        ST_FIN
    } crtc_state_t;

    typedef struct packed {
        logic       en;
        logic       ncs;
        logic       rnw;
        logic       rs;
        logic [7:0] di;
    } crtc_bus_t;

    localparam crtc_bus_t BUS_IDLE = '{en: 1'b0, ncs: 1'b1, rnw: 1'b1, rs: 1'b0, di: 8'h00};

    localparam int MODE_REGS = 12;

    localparam logic [7:0] MODE_TABLE [4][12] = '{
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07},
        '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07},
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70, 8'h02, 8'h01, 8'h06, 8'h07},
        '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19, 8'h02, 8'h0D, 8'h0B, 8'h0C}
    };

    function automatic crtc_bus_t bus_write(input logic rs, input logic [7:0] di);
        return '{en: 1'b1, ncs: 1'b0, rnw: 1'b0, rs: rs, di: di};
    endfunction

    // Out-of-table register numbers read as zero rather than indexing past the ROM.
    function automatic logic [7:0] mode_byte(input logic [1:0] mode, input logic [3:0] n);
        if (n < 4'(MODE_REGS))
            return MODE_TABLE[mode][n];
        return 8'h00;
    endfunction

endpackage

// File: rtl/crtc_mode_loader.sv
// Loads a full CRTC mode table (index/data write pairs) while letting CPU
// accesses pass through with priority; the CPU's index register is restored at the end.
module crtc_mode_loader
    import crtc_mode_pkg::*;
#(
    parameter int WAIT_VBLANK = 1,
    parameter int NREGS       = 12
) (
    input  logic       CLOCK,
    input  logic       nRESET,
    input  logic       vblank,
    input  logic       load_req,
    input  logic [1:0] mode_sel,
    input  logic       cpu_sel,
    input  logic       cpu_rnw,
    input  logic       cpu_rs,
    input  logic [7:0] cpu_di,
    output logic       crtc_en,
    output logic       crtc_ncs,
    output logic       crtc_rnw,
    output logic       crtc_rs,
    output logic [7:0] crtc_di,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_N = 4'(NREGS - 1);

    crtc_state_t state_reg, state_next;
    logic [3:0]  n_reg, n_next;
    logic [1:0]  mode_reg, mode_next;
    logic [4:0]  cpu_idx_reg, cpu_idx_next;
    logic        idx_dirty_reg, idx_dirty_next;
    crtc_bus_t   bus_reg, bus_next;
    logic        done_reg, done_next;

    logic cpu_idx_write;
    assign cpu_idx_write = cpu_sel && !cpu_rnw && !cpu_rs;

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            state_reg     <= ST_IDLE;
            n_reg         <= 4'd0;
            mode_reg      <= 2'd0;
            cpu_idx_reg   <= 5'd0;
            idx_dirty_reg <= 1'b0;
            bus_reg       <= BUS_IDLE;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            n_reg         <= n_next;
            mode_reg      <= mode_next;
            cpu_idx_reg   <= cpu_idx_next;
            idx_dirty_reg <= idx_dirty_next;
            bus_reg       <= bus_next;
            done_reg      <= done_next;
        end
    end

    // A CPU access freezes the sequencer for that cycle, whatever state it is in.
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        mode_next  = mode_reg;
        if (!cpu_sel) begin
            case (state_reg)
                ST_IDLE: begin
                    if (load_req) begin
                        mode_next  = mode_sel;
                        n_next     = 4'd0;
                        state_next = (WAIT_VBLANK != 0) ? ST_WAIT_VB : ST_ADDR;
                    end
                end
                ST_WAIT_VB: begin
                    if (vblank)
                        state_next = ST_ADDR;
                end
                ST_ADDR:    state_next = ST_DATA;
                ST_DATA: begin
                    if (idx_dirty_reg) begin
                        state_next = ST_ADDR;
                    end else if (n_reg == LAST_N) begin
                        state_next = ST_RESTORE;
                    end else begin
                        n_next     = n_reg + 4'd1;
                        state_next = ST_ADDR;
                    end
                end
                ST_RESTORE: state_next = ST_FIN;
                ST_FIN:     state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Shadow of the CPU's CRTC index so the sequencer can detect and undo interference.
    always_comb begin
        cpu_idx_next   = cpu_idx_reg;
        idx_dirty_next = idx_dirty_reg;
        if (cpu_idx_write) begin
            cpu_idx_next   = cpu_di[4:0];
            idx_dirty_next = 1'b1;
        end else if (!cpu_sel && state_reg == ST_ADDR) begin
            idx_dirty_next = 1'b0;
        end
    end

    always_comb begin
        bus_next  = BUS_IDLE;
        done_next = 1'b0;
        if (cpu_sel) begin
            bus_next = '{en: 1'b1, ncs: 1'b0, rnw: cpu_rnw, rs: cpu_rs, di: cpu_di};
        end else begin
            case (state_reg)
                ST_ADDR:    bus_next = bus_write(1'b0, {4'b0, n_reg});
                ST_DATA: begin
                    if (!idx_dirty_reg)
                        bus_next = bus_write(1'b1, mode_byte(mode_reg, n_reg));
                end
                ST_RESTORE: bus_next = bus_write(1'b0, {3'b0, cpu_idx_reg});
                ST_FIN:     done_next = 1'b1;
                default:    bus_next = BUS_IDLE;
            endcase
        end
    end

    assign crtc_en  = bus_reg.en;
    assign crtc_ncs = bus_reg.ncs;
    assign crtc_rnw = bus_reg.rnw;
    assign crtc_rs  = bus_reg.rs;
    assign crtc_di  = bus_reg.di;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;

endmodule
